mux_scan_sequencer: RTL and testbench

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux16to1.sv | 13 +
 rtl/mux_scan_sequencer.sv | 105 ++++++++++
 tb/tb_mux_scan_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and FSM state encoding for the mux scan sequencer.
// Provides DATA_W, SEL_W and the IDLE/SHIFT/DONE state enum.
package mux_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mux16to1.sv
// 16:1 bit multiplexer selecting in[sel].
// Ports: in (data word), sel (bit index), out (selected bit).
module mux16to1
    import mux_pkg::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    output logic              out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_scan_sequencer.sv
// Serialises a range of bits from a 16-bit word through a 16:1 mux,
// walking the select index up or down (mod 16) from first to last.
// Ports: clk, rst_n; load_valid/load_ready/load_data/first_idx/last_idx/dir
// (request); ser_valid/ser_ready/ser_bit/ser_last (bit stream);
// sel_dbg, busy, done (status).
module mux_scan_sequencer
    import mux_pkg::*;
#(
    parameter logic [SEL_W-1:0] IDLE_SEL = 4'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic [SEL_W-1:0]  first_idx,
    input  logic [SEL_W-1:0]  last_idx,
    input  logic              dir,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_bit,
    output logic              ser_last,
    output logic [SEL_W-1:0]  sel_dbg,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              dir_q, dir_d;
    logic              mux_out;

    mux16to1 u_mux (
        .in  (data_q),
        .sel (sel_q),
        .out (mux_out)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    data_d  = load_data;
                    last_d  = last_idx;
                    dir_d   = dir;
                    sel_d   = first_idx;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ser_ready) begin
                    if (sel_q == last_q) begin
                        state_d = ST_DONE;
                        sel_d   = IDLE_SEL;
                    end else if (dir_q) begin
                        // 4-bit arithmetic wraps 0 -> 15 and 15 -> 0
                        sel_d = sel_q - 4'd1;
                    end else begin
                        sel_d = sel_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                sel_d   = IDLE_SEL;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = IDLE_SEL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            last_q  <= '0;
            sel_q   <= IDLE_SEL;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign ser_valid  = (state_q == ST_SHIFT);
    assign ser_bit    = ser_valid & mux_out;
    assign ser_last   = ser_valid & (sel_q == last_q);
    assign sel_dbg    = sel_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed self-checking bench for mux_scan_sequencer.
// One task per scenario; expected values are hand-computed vectors.
module tb_mux_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic [3:0]  first_idx = '0;
    logic [3:0]  last_idx = '0;
    logic        dir = 1'b0;
    logic        ser_valid;
    logic        ser_ready = 1'b0;
    logic        ser_bit;
    logic        ser_last;
    logic [3:0]  sel_dbg;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_scan_sequencer #(.IDLE_SEL(4'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .first_idx  (first_idx),
        .last_idx   (last_idx),
        .dir        (dir),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_bit    (ser_bit),
        .ser_last   (ser_last),
        .sel_dbg    (sel_dbg),
        .busy       (busy),
        .done       (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] f,
                           input logic [3:0] l, input logic dr);
        load_valid = 1'b1;
        load_data  = d;
        first_idx  = f;
        last_idx   = l;
        dir        = dr;
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({load_ready, ser_valid, ser_bit, ser_last, busy, done} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_flags got %b want 100000",
                     {load_ready, ser_valid, ser_bit, ser_last, busy, done});
        end
        n_cmp++;
        if (sel_dbg !== 4'h0) begin
            n_err++;
            $display("FAIL reset_sel got %h want 0", sel_dbg);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_up();
        logic eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] es [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        ser_ready = 1'b1;
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL up_ready got %b want 1", load_ready);
        end
        do_load(16'h3f0a, 4'd0, 4'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({ser_valid, ser_bit, ser_last, sel_dbg} !==
                {1'b1, eb[i], (i == 3), es[i]}) begin
                n_err++;
                $display("FAIL up_bit[%0d] got v%b b%b l%b s%0d want v1 b%b l%b s%0d",
                         i, ser_valid, ser_bit, ser_last, sel_dbg, eb[i], (i == 3), es[i]);
            end
            step();
        end
        n_cmp++;
        if ({done, busy, ser_valid} !== 3'b110) begin
            n_err++;
            $display("FAIL up_done got %b want 110", {done, busy, ser_valid});
        end
        step();
        n_cmp++;
        if ({done, busy, load_ready, sel_dbg} !== {3'b001, 4'h0}) begin
            n_err++;
            $display("FAIL up_idle got %b want 0010000",
                     {done, busy, load_ready, sel_dbg});
        end
    endtask

    task automatic test_down();
        logic eb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] es [4] = '{4'd15, 4'd14, 4'd13, 4'd12};
        ser_ready = 1'b1;
        do_load(16'h3f0a, 4'd15, 4'd12, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({ser_valid, ser_bit, ser_last, sel_dbg} !==
                {1'b1, eb[i], (i == 3), es[i]}) begin
                n_err++;
                $display("FAIL down_bit[%0d] got b%b l%b s%0d want b%b l%b s%0d",
                         i, ser_bit, ser_last, sel_dbg, eb[i], (i == 3), es[i]);
            end
            step();
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL down_done got %b want 1", done);
        end
        step();
    endtask

    task automatic test_wrap();
        logic eb [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] es [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        ser_ready = 1'b1;
        do_load(16'h3f0a, 4'd14, 4'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({ser_valid, ser_bit, ser_last, sel_dbg} !==
                {1'b1, eb[i], (i == 3), es[i]}) begin
                n_err++;
                $display("FAIL wrap_bit[%0d] got b%b l%b s%0d want b%b l%b s%0d",
                         i, ser_bit, ser_last, sel_dbg, eb[i], (i == 3), es[i]);
            end
            step();
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_done got %b want 1", done);
        end
        step();
    endtask

    task automatic test_toggle();
        logic [15:0] word = 16'h3f0a;
        logic [3:0]  idx;
        do_load(word, 4'd0, 4'd15, 1'b0);
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            ser_ready = 1'b0;
            n_cmp++;
            if ({ser_valid, ser_bit, ser_last, sel_dbg} !==
                {1'b1, word[idx], (i == 15), idx}) begin
                n_err++;
                $display("FAIL tog_bit[%0d] got v%b b%b l%b s%0d want b%b",
                         i, ser_valid, ser_bit, ser_last, sel_dbg, word[idx]);
            end
            step();
            n_cmp++;
            if ({ser_valid, ser_bit, ser_last, sel_dbg} !==
                {1'b1, word[idx], (i == 15), idx}) begin
                n_err++;
                $display("FAIL tog_hold[%0d] got v%b b%b l%b s%0d want b%b s%0d",
                         i, ser_valid, ser_bit, ser_last, sel_dbg, word[idx], idx);
            end
            ser_ready = 1'b1;
            step();
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL tog_done got %b want 1", done);
        end
        step();
    endtask

    task automatic test_reset_mid();
        ser_ready = 1'b1;
        do_load(16'h3f0a, 4'd0, 4'd15, 1'b0);
        step();
        step();
        n_cmp++;
        if (sel_dbg !== 4'd2) begin
            n_err++;
            $display("FAIL rmid_pre got %0d want 2", sel_dbg);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({load_ready, ser_valid, ser_bit, ser_last, busy, done, sel_dbg} !==
            {6'b100000, 4'h0}) begin
            n_err++;
            $display("FAIL rmid_async got %b want 1000000000",
                     {load_ready, ser_valid, ser_bit, ser_last, busy, done, sel_dbg});
        end
        #2;
        rst_n = 1'b1;
        do_load(16'h3f0a, 4'd15, 4'd12, 1'b1);
        n_cmp++;
        if ({ser_valid, ser_bit, sel_dbg} !== {1'b1, 1'b0, 4'd15}) begin
            n_err++;
            $display("FAIL rmid_reload got v%b b%b s%0d want v1 b0 s15",
                     ser_valid, ser_bit, sel_dbg);
        end
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_done got %b want 1", done);
        end
        step();
    endtask

    task automatic test_single();
        ser_ready = 1'b0;
        do_load(16'h0020, 4'd5, 4'd5, 1'b0);
        n_cmp++;
        if ({ser_valid, ser_bit, ser_last, sel_dbg} !== {3'b111, 4'd5}) begin
            n_err++;
            $display("FAIL single_bit got v%b b%b l%b s%0d want v1 b1 l1 s5",
                     ser_valid, ser_bit, ser_last, sel_dbg);
        end
        load_valid = 1'b1;
        load_data  = 16'hffff;
        first_idx  = 4'd0;
        last_idx   = 4'd9;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (load_ready !== 1'b0) begin
                n_err++;
                $display("FAIL single_nordy[%0d] got %b want 0", i, load_ready);
            end
            step();
            n_cmp++;
            if ({ser_bit, ser_last, sel_dbg} !== {2'b11, 4'd5}) begin
                n_err++;
                $display("FAIL single_keep[%0d] got b%b l%b s%0d want b1 l1 s5",
                         i, ser_bit, ser_last, sel_dbg);
            end
        end
        load_valid = 1'b0;
        ser_ready  = 1'b1;
        step();
        n_cmp++;
        if ({done, ser_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL single_done got %b want 10", {done, ser_valid});
        end
        step();
        n_cmp++;
        if ({load_ready, busy, ser_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL single_idle got %b want 100", {load_ready, busy, ser_valid});
        end
        step();
        n_cmp++;
        if ({load_ready, ser_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL single_noqueue got %b want 10", {load_ready, ser_valid});
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_wrap();
        test_toggle();
        test_reset_mid();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
